rfemu_burst_ctrl: RTL

Sequencer for the RF-emulator playback buffer.
- Watches the AXI-Stream load of one pulse (up to 64 × 128-bit beats) into the emulator.
- Once armed, issues a one-cycle start to the emulator once per pulse repetition interval (PRI), for a programmed number of pulses.
- Counts the played-back beats per pulse and flags overruns and configuration errors.
- Sits between the software register block and the emulator, alongside the MM2S DMA stream.

---
 rtl/rfemu_burst_ctrl_if.sv | 41 ++++
 rtl/rfemu_burst_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rfemu_burst_ctrl_if.sv
// Control/status bundle of the RF-emulator burst sequencer.
// Carries the software configuration strobes, the DMA load-stream monitor
// taps, the emulator playback handshake and the sequencer status outputs.
// The slave modport is the sequencer itself; the master modport is its
// environment (register block, DMA monitor, emulator).
interface rfemu_burst_ctrl_if #(
    parameter int PRI_W  = 24,
    parameter int CNT_W  = 16,
    parameter int BEAT_W = 7
);
    logic              cfg_arm;
    logic              cfg_abort;
    logic [CNT_W-1:0]  cfg_num_pulses;
    logic [PRI_W-1:0]  cfg_pri;
    logic [BEAT_W-1:0] cfg_beats;
    logic              ld_tvalid;
    logic              ld_tready;
    logic              ld_tlast;
    logic              emu_start;
    logic              emu_valid;
    logic              emu_ready;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pulse_cnt;
    logic              err_cfg;
    logic              err_ovr;
    logic              err_timeout;
    logic [2:0]        state_dbg;

    modport master (
        output cfg_arm, cfg_abort, cfg_num_pulses, cfg_pri, cfg_beats,
        output ld_tvalid, ld_tready, ld_tlast, emu_valid, emu_ready,
        input  emu_start, busy, done, pulse_cnt, err_cfg, err_ovr, err_timeout, state_dbg
    );

    modport slave (
        input  cfg_arm, cfg_abort, cfg_num_pulses, cfg_pri, cfg_beats,
        input  ld_tvalid, ld_tready, ld_tlast, emu_valid, emu_ready,
        output emu_start, busy, done, pulse_cnt, err_cfg, err_ovr, err_timeout, state_dbg
    );
endinterface

// File: rtl/rfemu_burst_ctrl.sv
// RF-emulator playback sequencer.
// Waits for one pulse to be loaded over the DMA stream, then strobes
// emu_start once every cfg_pri cycles for cfg_num_pulses pulses, counting the
// played-back beats and flagging overruns and bad configuration.
// Optional load timeout: define RFEMU_BURST_CTRL_TIMEOUT_EN.
//
// Handshakes: a stream beat transfers on a cycle where valid && ready are both
// high at the rising clock edge; neither side may make valid depend on ready.
// The ld_* signals are only monitored, the sequencer never drives tready.
module rfemu_burst_ctrl #(
    parameter int PRI_W  = 24,
    parameter int CNT_W  = 16,
    parameter int BEAT_W = 7
) (
    input logic               clk,
    input logic               rstn,
    rfemu_burst_ctrl_if.slave bus
);
    localparam int MAX_BEATS = 64;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FIRE = 3'd2,
        S_PLAY = 3'd3,
        S_WAIT = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  num_q, pulse_cnt_q;
    logic [PRI_W-1:0]  pri_q, pri_cnt_q;
    logic [BEAT_W-1:0] beats_q, beat_cnt_q;
    logic              err_cfg_q, err_ovr_q, done_q;
    logic              arm_ok, cfg_bad, ld_last, beat_hs, beat_last;
    logic              pri_exp, more, fire_ok, set_ovr;
`ifdef RFEMU_BURST_CTRL_TIMEOUT_EN
    logic [19:0]       to_cnt_q;
    logic              err_timeout_q, set_to;
`endif

    // Arm is only honoured in IDLE and loses to a simultaneous abort.
    assign arm_ok   = (state_q == S_IDLE) && bus.cfg_arm && !bus.cfg_abort;
    assign cfg_bad  = (bus.cfg_beats == '0) || (int'(bus.cfg_beats) > MAX_BEATS) ||
                      ({1'b0, bus.cfg_pri} < ((PRI_W+1)'(bus.cfg_beats) + (PRI_W+1)'(4)));
    assign ld_last  = bus.ld_tvalid && bus.ld_tready && bus.ld_tlast;
    assign beat_hs  = (state_q == S_PLAY) && bus.emu_valid && bus.emu_ready;
    assign beat_last = beat_hs && ((beat_cnt_q + BEAT_W'(1)) == beats_q);
    assign pri_exp  = (pri_cnt_q == (pri_q - PRI_W'(1)));
    assign more     = (pulse_cnt_q < num_q);
    // The start strobe is suppressed in the cycle an abort arrives.
    assign fire_ok  = (state_q == S_FIRE) && !bus.cfg_abort;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        set_ovr = 1'b0;
`ifdef RFEMU_BURST_CTRL_TIMEOUT_EN
        set_to  = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (arm_ok && !cfg_bad && (bus.cfg_num_pulses != '0)) state_d = S_LOAD;
            S_LOAD: begin
                if (ld_last) state_d = S_FIRE;
`ifdef RFEMU_BURST_CTRL_TIMEOUT_EN
                else if (to_cnt_q == '1) begin
                    set_to  = 1'b1;
                    state_d = S_FIN;
                end
`endif
            end
            S_FIRE: state_d = S_PLAY;
            S_PLAY: begin
                // A last beat landing on PRI expiry counts as complete; the
                // WAIT decision is taken in that same cycle so the next start
                // still lands exactly cfg_pri cycles after the previous one.
                if (beat_last) state_d = pri_exp ? (more ? S_FIRE : S_FIN) : S_WAIT;
                else if (pri_exp) begin
                    set_ovr = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_WAIT: if (pri_exp) state_d = more ? S_FIRE : S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.cfg_abort && (state_q != S_IDLE) && (state_q != S_FIN)) begin
            state_d = S_FIN;
            set_ovr = 1'b0;
`ifdef RFEMU_BURST_CTRL_TIMEOUT_EN
            set_to  = 1'b0;
`endif
        end
    end

    // Config latch, pulse counter, sticky errors and the done strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_q       <= '0;
            pri_q       <= '0;
            beats_q     <= '0;
            pulse_cnt_q <= '0;
            err_cfg_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_d == S_FIN) || (arm_ok && (cfg_bad || (bus.cfg_num_pulses == '0)));
            if (arm_ok) begin
                num_q       <= bus.cfg_num_pulses;
                pri_q       <= bus.cfg_pri;
                beats_q     <= bus.cfg_beats;
                pulse_cnt_q <= '0;
                err_cfg_q   <= cfg_bad;
                err_ovr_q   <= 1'b0;
            end else begin
                if (fire_ok && (pulse_cnt_q != '1)) pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
                if (set_ovr) err_ovr_q <= 1'b1;
            end
        end
    end

    // PRI and beat counters; both restart when a pulse is fired.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pri_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else if (state_d == S_FIRE) begin
            pri_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            if ((state_q == S_FIRE) || (state_q == S_PLAY) || (state_q == S_WAIT))
                pri_cnt_q <= pri_cnt_q + PRI_W'(1);
            if (beat_hs) beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
        end
    end

`ifdef RFEMU_BURST_CTRL_TIMEOUT_EN
    // Load watchdog: counts LOAD cycles, sticky flag on expiry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == S_LOAD) ? to_cnt_q + 20'd1 : '0;
            if (arm_ok)      err_timeout_q <= 1'b0;
            else if (set_to) err_timeout_q <= 1'b1;
        end
    end
    assign bus.err_timeout = err_timeout_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.emu_start = fire_ok;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pulse_cnt_q;
    assign bus.err_cfg   = err_cfg_q;
    assign bus.err_ovr   = err_ovr_q;
    assign bus.state_dbg = state_q;
endmodule
